data_mem_ctrl: RTL and testbench

- Data-side memory slave that sits directly downstream of the core's memory stage.
- Consumes the core's data request bus (req/gnt/rvalid handshake, byte enables, write flag) and serves it from an internal word-organised RAM.
- Inserts a programmable number of wait states, so the stall paths of the load/store pipeline are exercised on FPGA and in simulation.
- Flags out-of-range accesses.

---
 rtl/data_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// data_mem_ctrl: data-side memory slave behind the core's memory stage.
// It accepts one req/gnt transaction at a time and inserts WAIT_STATES
// idle cycles before the RAM access. It then returns a one-cycle rvalid
// pulse that carries read data or a write acknowledge. An access above
// the RAM depth is reported on data_err_o and does not touch the RAM.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   data_req_i      request valid from core
//   data_addr_i     byte address
//   data_wr_i       1 = write, 0 = read
//   data_be_i       byte-lane enables
//   data_wdata_i    write data
//   data_gnt_o      request accepted this cycle (combinational, IDLE only)
//   data_rvalid_o   one-cycle response pulse
//   data_rdata_o    read data, valid with rvalid (0 for writes / errors)
//   data_err_o      out-of-range access, valid with rvalid
module data_mem_ctrl #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned MEM_ADDR_WIDTH     = 32,
  parameter int unsigned MEM_TRANSFER_WIDTH = 4,
  parameter int unsigned DEPTH_LOG2         = 10,
  parameter int unsigned WAIT_STATES        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0]     data_addr_i,
  input  logic                          data_wr_i,
  input  logic [MEM_TRANSFER_WIDTH-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]         data_wdata_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  output logic [DATA_WIDTH-1:0]         data_rdata_o,
  output logic                          data_err_o
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_LSB   = 2;
  localparam int unsigned RANGE_LSB = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Captured request, held from grant until the response has been sent.
  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0]     addr;
    logic                          wr;
    logic [MEM_TRANSFER_WIDTH-1:0] be;
    logic [DATA_WIDTH-1:0]         wdata;
  } req_t;

  state_t                 state;
  logic [CNT_W-1:0]       wait_cnt;
  req_t                   req_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   oob_c;
  logic [DEPTH_LOG2-1:0]  idx_c;
  logic                   mem_we_c;

  // Grant only in IDLE, and never while reset is held.
  assign data_gnt_o = data_req_i && (state == IDLE) && !rst;

  // Word index and range check. addr[1:0] is ignored because the byte
  // enables alone select the lanes.
  always_comb begin
    idx_c    = req_q.addr[IDX_LSB +: DEPTH_LOG2];
    oob_c    = |(req_q.addr >> RANGE_LSB);
    mem_we_c = (state == ACCESS) && req_q.wr && !oob_c && !rst;
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_rvalid_o <= 1'b0;
          data_err_o    <= 1'b0;
          if (data_gnt_o) begin
            req_q.addr  <= data_addr_i;
            req_q.wr    <= data_wr_i;
            req_q.be    <= data_be_i;
            req_q.wdata <= data_wdata_i;
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_W'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ACCESS: begin
          // The response registers are loaded here, so rvalid is high during RESP.
          data_rvalid_o <= 1'b1;
          data_err_o    <= oob_c;
          data_rdata_o  <= (req_q.wr || oob_c) ? '0 : mem[idx_c];
          state         <= RESP;
        end
        RESP: begin
          data_rvalid_o <= 1'b0;
          data_err_o    <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port. It is blocked while rst is high, so a write that is
  // in ACCESS at the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(MEM_TRANSFER_WIDTH); b++) begin
        if (req_q.be[b]) begin
          mem[idx_c][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
// Directed bench for data_mem_ctrl. dut1 is built with WAIT_STATES=1 and
// dut0 with WAIT_STATES=0. Both share one clock.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        req1, wr1, gnt1, rvalid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;

  logic        req0, wr0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst),
    .data_req_i(req1), .data_addr_i(addr1), .data_wr_i(wr1),
    .data_be_i(be1), .data_wdata_i(wdata1),
    .data_gnt_o(gnt1), .data_rvalid_o(rvalid1),
    .data_rdata_o(rdata1), .data_err_o(err1)
  );

  data_mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .data_req_i(req0), .data_addr_i(addr0), .data_wr_i(wr0),
    .data_be_i(be0), .data_wdata_i(wdata0),
    .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_rdata_o(rdata0), .data_err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    if (sel) begin
      req0 = req; wr0 = wr; addr0 = addr; be0 = be; wdata0 = wd;
    end else begin
      req1 = req; wr1 = wr; addr1 = addr; be1 = be; wdata1 = wd;
    end
  endtask

  // Called at posedge+1 with the selected DUT in IDLE. It checks the
  // grant, the exact response latency and the one-cycle rvalid pulse. It
  // returns at posedge+1 of the first cycle after the response.
  task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input string tag,
                     output logic [31:0] rd, output logic er);
    int  n;
    bit  seen;
    drive(sel, 1'b1, wr, addr, be, wd);
    #1;
    chk({tag, " gnt"}, 32'(sel ? gnt0 : gnt1), 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    seen = 0; n = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      if ((sel ? rvalid0 : rvalid1) === 1'b1) begin
        seen = 1; n = k;
        rd = sel ? rdata0 : rdata1;
        er = sel ? err0 : err1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, " latency"}, 32'(n), sel ? 32'd2 : 32'd3);
    @(posedge clk); #1;
    chk({tag, " rvalid pulse"}, 32'(sel ? rvalid0 : rvalid1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ng, nr;
    int          gcyc [4];

    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt1", 32'(gnt1), 32'd0);
    chk("reset gnt0", 32'(gnt0), 32'd0);
    chk("reset rvalid1", 32'(rvalid1), 32'd0);
    chk("reset err1", 32'(err1), 32'd0);
    chk("reset rdata1", rdata1, 32'h0);
    chk("reset rvalid0", 32'(rvalid0), 32'd0);
    chk("reset rdata0", rdata0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write and read-back.
    txn(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr10", rd, er);
    chk("wr10 err", 32'(er), 32'd0);
    chk("wr10 rdata", rd, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "rd10", rd, er);
    chk("rd10 err", 32'(er), 32'd0);
    chk("rd10 rdata", rd, 32'hDEADBEEF);

    // Byte lanes: lanes 0 and 2 are replaced.
    txn(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, "wr20a", rd, er);
    txn(1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "wr20b", rd, er);
    txn(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, "rd20", rd, er);
    chk("rd20 rdata", rd, 32'h11BB33DD);

    // Out of range. 0x1000 would alias word 0 if the range check were missing.
    txn(1'b0, 1'b1, 32'h0, 4'hF, 32'h5A5A0001, "wr0", rd, er);
    txn(1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, "wr1000", rd, er);
    chk("wr1000 err", 32'(er), 32'd1);
    chk("wr1000 rdata", rd, 32'h0);
    txn(1'b0, 1'b0, 32'h1000, 4'hF, 32'h0, "rd1000", rd, er);
    chk("rd1000 err", 32'(er), 32'd1);
    chk("rd1000 rdata", rd, 32'h0);
    txn(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, "rd0", rd, er);
    chk("rd0 err", 32'(er), 32'd0);
    chk("rd0 rdata", rd, 32'h5A5A0001);

    // Back-to-back: req held high until it has been granted three times.
    ng = 0; nr = 0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (gnt1 === 1'b1) begin
        if (ng < 4) gcyc[ng] = c;
        ng++;
      end
      if (rvalid1 === 1'b1) begin
        nr++;
        chk("b2b rdata", rdata1, 32'hDEADBEEF);
      end
      @(posedge clk); #1;
      if (ng >= 3) drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    chk("b2b gnt count", 32'(ng), 32'd3);
    chk("b2b gnt0 cycle", 32'(gcyc[0]), 32'd0);
    chk("b2b gnt1 cycle", 32'(gcyc[1]), 32'd4);
    chk("b2b gnt2 cycle", 32'(gcyc[2]), 32'd8);
    chk("b2b rvalid count", 32'(nr), 32'd3);

    // WAIT_STATES=0 build: latency 2, and a be=0 write is a no-op.
    txn(1'b1, 1'b1, 32'h8, 4'hF, 32'h01020304, "ws0 wr8", rd, er);
    txn(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, "ws0 rd8", rd, er);
    chk("ws0 rd8 rdata", rd, 32'h01020304);
    txn(1'b1, 1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, "ws0 be0", rd, er);
    chk("ws0 be0 err", 32'(er), 32'd0);
    txn(1'b1, 1'b0, 32'h8, 4'hF, 32'h0, "ws0 rd8b", rd, er);
    chk("ws0 rd8b rdata", rd, 32'h01020304);

    // Reset while the write is in WAIT: the write is dropped with no response.
    txn(1'b0, 1'b1, 32'h40, 4'hF, 32'h0, "wr40 init", rd, er);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    #1;
    chk("rst gnt", 32'(gnt1), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst rvalid", 32'(rvalid1), 32'd0);
    txn(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, "rd40", rd, er);
    chk("rd40 rdata", rd, 32'h0);
    chk("rd40 err", 32'(er), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
